// File: rtl/rpn_stack_calc_pkg.sv
// Shared types for the RPN calculator core: opcodes, FSM states, undo kinds and flag bit positions.
package rpn_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  // Encodings double as the LED status pattern.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_LOAD = 3'b010,
    ST_EXEC = 3'b100,
    ST_ERR  = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    UNDO_NONE = 2'd0,
    UNDO_PUSH = 2'd1,
    UNDO_OP   = 2'd2
  } undo_kind_t;

  localparam int unsigned NUM_FLAGS = 4;
  localparam int unsigned FLAG_N    = 3;
  localparam int unsigned FLAG_Z    = 2;
  localparam int unsigned FLAG_C    = 1;
  localparam int unsigned FLAG_V    = 0;

  function automatic state_t rest_state(input logic nonempty);
    return nonempty ? ST_LOAD : ST_IDLE;
  endfunction

endpackage

// File: rtl/rpn_stack_calc_if.sv
// Command/status bundle between the button logic, the calculator core and the display driver.
interface rpn_stack_calc_if
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             enter;
  logic             op_go;
  logic             undo;
  op_t              op;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [CW-1:0]    count;
  logic [3:0]       flags;
  logic             error;
  logic [2:0]       status;

  modport master (
    output enter, op_go, undo, op, data_in,
    input  top, next, count, flags, error, status
  );

  modport slave (
    input  enter, op_go, undo, op, data_in,
    output top, next, count, flags, error, status
  );
endinterface

// File: rtl/rpn_stack_calc_alu.sv
// Combinational ALU for the RPN core: ADD/SUB/AND/OR with {N,Z,C,V} flags.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_t              op_i,
  output logic [WIDTH-1:0] result_c_o,
  output logic [3:0]       flags_c_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Borrow of A-B shows up as the extra top bit of the widened difference.
  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op_i)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff[WIDTH-1:0];
        c   = diff[WIDTH];
        v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      default: res = '0;
    endcase
  end

  always_comb begin
    flags_c_o         = '0;
    flags_c_o[FLAG_N] = res[WIDTH-1];
    flags_c_o[FLAG_Z] = (res == '0);
    flags_c_o[FLAG_C] = c;
    flags_c_o[FLAG_V] = v;
    result_c_o        = res;
  end

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN calculator core: operand stack, two-cycle op write-back, sticky error and one-level undo.
// Undo record is built only when RPN_UNDO_EN is defined; otherwise undo only clears ERR.
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  rpn_stack_calc_if.slave  bus
);

  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned LAST = DEPTH - 1;

  typedef logic [WIDTH-1:0] word_t;

  state_t        state_q, state_d;
  word_t         stk_q [DEPTH];
  word_t         stk_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    flags_q, flags_d;
  logic          err_q, err_d;
  word_t         a_q, a_d;
  word_t         b_q, b_d;
  op_t           op_q, op_d;
  word_t         alu_res;
  logic [3:0]    alu_flags;

`ifdef RPN_UNDO_EN
  undo_kind_t    kind_q, kind_d;
  word_t         ua_q, ua_d;
  word_t         ub_q, ub_d;
`endif

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .result_c_o (alu_res),
    .flags_c_o  (alu_flags)
  );

  // Next-state: priority undo > op_go > enter; vacated slots are zeroed so top/next read 0 when empty.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < DEPTH; i++) stk_d[i] = stk_q[i];
    cnt_d   = cnt_q;
    flags_d = flags_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
`ifdef RPN_UNDO_EN
    kind_d  = kind_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
`endif

    case (state_q)
      ST_IDLE, ST_LOAD: begin
`ifdef RPN_UNDO_EN
        if (bus.undo) begin
          if (kind_q == UNDO_PUSH) begin
            for (int i = 0; i < LAST; i++) stk_d[i] = stk_q[i+1];
            stk_d[LAST] = '0;
            cnt_d       = cnt_q - CW'(1);
            state_d     = rest_state(cnt_q > CW'(1));
            kind_d      = UNDO_NONE;
          end else if (kind_q == UNDO_OP) begin
            stk_d[0] = ub_q;
            stk_d[1] = ua_q;
            for (int i = 2; i < DEPTH; i++) stk_d[i] = stk_q[i-1];
            cnt_d    = cnt_q + CW'(1);
            flags_d  = '0;
            state_d  = ST_LOAD;
            kind_d   = UNDO_NONE;
          end
        end else
`endif
        if (bus.op_go) begin
          if (cnt_q >= CW'(2)) begin
            a_d     = stk_q[1];
            b_d     = stk_q[0];
            op_d    = bus.op;
            state_d = ST_EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end else if (bus.enter) begin
          if (cnt_q == CW'(DEPTH)) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            for (int i = 1; i < DEPTH; i++) stk_d[i] = stk_q[i-1];
            stk_d[0] = bus.data_in;
            cnt_d    = cnt_q + CW'(1);
            state_d  = ST_LOAD;
`ifdef RPN_UNDO_EN
            kind_d   = UNDO_PUSH;
`endif
          end
        end
      end

      ST_EXEC: begin
        stk_d[0] = alu_res;
        for (int i = 1; i < LAST; i++) stk_d[i] = stk_q[i+1];
        stk_d[LAST] = '0;
        cnt_d       = cnt_q - CW'(1);
        flags_d     = alu_flags;
        state_d     = ST_LOAD;
`ifdef RPN_UNDO_EN
        kind_d      = UNDO_OP;
        ua_d        = a_q;
        ub_d        = b_q;
`endif
      end

      ST_ERR: begin
        if (bus.undo) begin
          err_d   = 1'b0;
          state_d = rest_state(cnt_q != '0);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
`ifdef RPN_UNDO_EN
      kind_q  <= UNDO_NONE;
      ua_q    <= '0;
      ub_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= stk_d[i];
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
`ifdef RPN_UNDO_EN
      kind_q  <= kind_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
`endif
    end
  end

  assign bus.top    = stk_q[0];
  assign bus.next   = stk_q[1];
  assign bus.count  = cnt_q;
  assign bus.flags  = flags_q;
  assign bus.error  = err_q;
  assign bus.status = state_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed self-checking bench for rpn_stack_calc (WIDTH=16, DEPTH=4).
module tb_rpn_stack_calc;
  import rpn_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  rpn_stack_calc_if #(.WIDTH(16), .DEPTH(4)) bus ();

  rpn_stack_calc #(.WIDTH(16), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    bus.data_in = d;
    bus.enter   = 1'b1;
    tick();
    bus.enter   = 1'b0;
  endtask

  task automatic go(input op_t o);
    bus.op    = o;
    bus.op_go = 1'b1;
    tick();
    bus.op_go = 1'b0;
  endtask

  task automatic do_undo();
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
  endtask

  // Fresh stack, push A then B, apply op, check the EXEC pass-through and the write-back.
  task automatic alu_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input op_t o, input logic [15:0] exp_r, input logic [3:0] exp_f);
    do_reset();
    push(a);
    push(b);
    go(o);
    chk({tag, "_exec"}, 32'(bus.status), 32'(3'b100));
    tick();
    chk({tag, "_top"},   32'(bus.top),    32'(exp_r));
    chk({tag, "_flags"}, 32'(bus.flags),  32'(exp_f));
    chk({tag, "_count"}, 32'(bus.count),  32'd1);
    chk({tag, "_stat"},  32'(bus.status), 32'(3'b010));
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.enter   = 1'b0;
    bus.op_go   = 1'b0;
    bus.undo    = 1'b0;
    bus.op      = OP_ADD;
    bus.data_in = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_count",  32'(bus.count),  32'd0);
    chk("rst_top",    32'(bus.top),    32'd0);
    chk("rst_next",   32'(bus.next),   32'd0);
    chk("rst_flags",  32'(bus.flags),  32'd0);
    chk("rst_error",  32'(bus.error),  32'd0);
    chk("rst_status", 32'(bus.status), 32'(3'b001));

    // Push latency and ordering
    push(16'h0005);
    chk("p1_top",    32'(bus.top),    32'h5);
    chk("p1_count",  32'(bus.count),  32'd1);
    chk("p1_status", 32'(bus.status), 32'(3'b010));
    push(16'h0003);
    chk("p2_top",   32'(bus.top),   32'h3);
    chk("p2_next",  32'(bus.next),  32'h5);
    chk("p2_count", 32'(bus.count), 32'd2);

    // 5 - 3 on the already-loaded stack
    go(OP_SUB);
    chk("sub_exec",  32'(bus.status), 32'(3'b100));
    chk("sub_cnt_e", 32'(bus.count),  32'd2);
    tick();
    chk("sub_top",   32'(bus.top),    32'h2);
    chk("sub_count", 32'(bus.count),  32'd1);
    chk("sub_flags", 32'(bus.flags),  32'h0);
    chk("sub_next",  32'(bus.next),   32'h0);

    // ALU vectors: {N,Z,C,V}
    alu_case("add_ovf",  16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 4'b1001);
    alu_case("add_cz",   16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 4'b0110);
    alu_case("sub_brw",  16'h0003, 16'h0005, OP_SUB, 16'hFFFE, 4'b1010);
    alu_case("sub_zero", 16'h0005, 16'h0005, OP_SUB, 16'h0000, 4'b0100);
    alu_case("sub_ovf",  16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 4'b0001);
    alu_case("and",      16'h0F0F, 16'h00FF, OP_AND, 16'h000F, 4'b0000);
    alu_case("or",       16'h00F0, 16'h000F, OP_OR,  16'h00FF, 4'b0000);

    // Undo after an op
    do_undo();
`ifdef RPN_UNDO_EN
    chk("uop_count", 32'(bus.count),  32'd2);
    chk("uop_top",   32'(bus.top),    32'h000F);
    chk("uop_next",  32'(bus.next),   32'h00F0);
    chk("uop_flags", 32'(bus.flags),  32'h0);
    chk("uop_stat",  32'(bus.status), 32'(3'b010));
    do_undo();
    chk("uop2_count", 32'(bus.count), 32'd2);
    chk("uop2_top",   32'(bus.top),   32'h000F);
    push(16'h0009);
    do_undo();
    chk("upush_count", 32'(bus.count), 32'd2);
    chk("upush_top",   32'(bus.top),   32'h000F);
`else
    chk("uop_count", 32'(bus.count), 32'd1);
    chk("uop_top",   32'(bus.top),   32'h00FF);
`endif

    // Overflow on the fifth push
    do_reset();
    for (int i = 1; i <= 5; i++) push(16'(i));
    chk("ovf_error",  32'(bus.error),  32'd1);
    chk("ovf_status", 32'(bus.status), 32'(3'b111));
    chk("ovf_count",  32'(bus.count),  32'd4);
    chk("ovf_top",    32'(bus.top),    32'h4);
    chk("ovf_next",   32'(bus.next),   32'h3);
    do_undo();
    chk("ovf_u_error",  32'(bus.error),  32'd0);
    chk("ovf_u_count",  32'(bus.count),  32'd4);
    chk("ovf_u_status", 32'(bus.status), 32'(3'b010));

    // Underflow: op with one entry
    do_reset();
    push(16'h0001);
    go(OP_ADD);
    chk("udf_status", 32'(bus.status), 32'(3'b111));
    chk("udf_error",  32'(bus.error),  32'd1);
    chk("udf_top",    32'(bus.top),    32'h1);
    chk("udf_count",  32'(bus.count),  32'd1);
    push(16'h0009);
    chk("err_ent_cnt", 32'(bus.count),  32'd1);
    chk("err_ent_top", 32'(bus.top),    32'h1);
    chk("err_ent_st",  32'(bus.status), 32'(3'b111));
    do_undo();
    chk("udf_u_status", 32'(bus.status), 32'(3'b010));
    chk("udf_u_count",  32'(bus.count),  32'd1);
    chk("udf_u_error",  32'(bus.error),  32'd0);

    // Reset during EXEC discards the op and clears flags
    do_reset();
    push(16'h7FFF);
    push(16'h0001);
    go(OP_ADD);
    tick();
    chk("pre_flags", 32'(bus.flags), 32'h9);
    push(16'h0002);
    go(OP_ADD);
    chk("rx_exec", 32'(bus.status), 32'(3'b100));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rx_count",  32'(bus.count),  32'd0);
    chk("rx_top",    32'(bus.top),    32'd0);
    chk("rx_flags",  32'(bus.flags),  32'd0);
    chk("rx_status", 32'(bus.status), 32'(3'b001));

    // enter and op_go together: only the op runs
    push(16'h0008);
    push(16'h0003);
    bus.data_in = 16'h0055;
    bus.op      = OP_SUB;
    bus.enter   = 1'b1;
    bus.op_go   = 1'b1;
    tick();
    bus.enter   = 1'b0;
    bus.op_go   = 1'b0;
    chk("both_exec",  32'(bus.status), 32'(3'b100));
    chk("both_cnt_e", 32'(bus.count),  32'd2);
    tick();
    chk("both_top",   32'(bus.top),    32'h5);
    chk("both_count", 32'(bus.count),  32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
